// File: rtl/prog_if_pkg.sv
// Shared definitions for the programming-key front end: FSM encoding,
// default timing constants and the auto-repeat multipliers.
package prog_if_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPressDb = 3'd1,
    StLatch   = 3'd2,
    StPulse   = 3'd3,
    StHeld    = 3'd4,
    StRelDb   = 3'd5
  } prog_state_e;

  // 20 ms debounce and 1 ms strobe at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_PULSE_CYCLES    = 50000;
  localparam int unsigned DEF_CNT_W           = 20;

  // Auto-repeat delays, in units of the debounce time
  localparam int unsigned RPT_FIRST_MULT = 25;
  localparam int unsigned RPT_NEXT_MULT  = 10;

endpackage

// File: rtl/prog_key_conditioner_if.sv
// Output bundle from the key conditioner to the memory programmer stage.
interface prog_key_conditioner_if;
  logic       prog_clock;
  logic       prog_wr_en;
  logic [7:0] prog_code;
  logic       busy;

  modport master (
    output prog_clock,
    output prog_wr_en,
    output prog_code,
    output busy
  );

  modport slave (
    input prog_clock,
    input prog_wr_en,
    input prog_code,
    input busy
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync2 #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/prog_key_conditioner.sv
// Debounces the programming push button and produces one clean prog_clock
// strobe per accepted press, with switch data captured one cycle before the
// strobe rises and held until the next press.
// Optional macro AUTO_REPEAT_EN: while the key stays held, re-strobe after
// 25x the debounce time, then every 10x, recapturing the switches each time.
module prog_key_conditioner
  import prog_if_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                          clock,
  input  logic                          reset_N,
  input  logic                          key_N,
  input  logic                          sw_wr_en,
  input  logic [7:0]                    sw_code,
  prog_key_conditioner_if.master        prog
);

  localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYCLES - 1);

  logic       key_s;
  logic [8:0] sw_s;

  sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_key_sync (
    .clock   (clock),
    .reset_N (reset_N),
    .d       (key_N),
    .q       (key_s)
  );

  sync2 #(
    .WIDTH     (9),
    .RESET_VAL (9'h000)
  ) u_sw_sync (
    .clock   (clock),
    .reset_N (reset_N),
    .d       ({sw_wr_en, sw_code}),
    .q       (sw_s)
  );

  prog_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             prog_clock_q;
  logic             prog_wr_en_q;
  logic [7:0]       prog_code_q;

  // Saturating increment: the timer never wraps
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned   RptW         = $clog2(RPT_FIRST_MULT * DEBOUNCE_CYCLES + 1);
  localparam logic [RptW-1:0] RptFirstLast = RptW'(RPT_FIRST_MULT * DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] RptNextLast  = RptW'(RPT_NEXT_MULT * DEBOUNCE_CYCLES - 1);

  logic [RptW-1:0] rpt_q, rpt_d, rpt_inc;
  logic            rpt_first_q, rpt_first_d;
  logic            rpt_fire;

  assign rpt_inc  = (rpt_q == '1) ? rpt_q : rpt_q + 1'b1;
  assign rpt_fire = !key_s && (rpt_q >= (rpt_first_q ? RptFirstLast : RptNextLast));

  // Repeat timer: first delay measured from HELD entry, later ones from each
  // re-latch so the strobe period is exactly the repeat interval
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    case (state_q)
      StIdle, StPressDb: begin
        rpt_d       = '0;
        rpt_first_d = 1'b1;
      end
      StRelDb: rpt_d = '0;
      StHeld: begin
        if (rpt_fire) begin
          rpt_d       = '0;
          rpt_first_d = 1'b0;
        end else if (!key_s) begin
          rpt_d = rpt_inc;
        end
      end
      StLatch, StPulse: begin
        if (!rpt_first_q) rpt_d = rpt_inc;
      end
      default: rpt_d = '0;
    endcase
  end

  // Repeat timer state
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  // Next-state and timer logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (!key_s) state_d = StPressDb;
      end
      StPressDb: begin
        if (key_s) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (timer_q >= DbLast) begin
          state_d = StLatch;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      StLatch: begin
        state_d = StPulse;
        timer_d = '0;
      end
      StPulse: begin
        // Key release here is ignored; HELD/REL_DB handle it
        if (timer_q >= PulseLast) begin
          state_d = StHeld;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      StHeld: begin
        timer_d = '0;
        if (key_s) begin
          state_d = StRelDb;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_fire) begin
          state_d = StLatch;
        end
`endif
      end
      StRelDb: begin
        if (!key_s) begin
          state_d = StHeld;
          timer_d = '0;
        end else if (timer_q >= DbLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and registered outputs; data is captured on LATCH entry so
  // it is stable a full cycle before prog_clock rises
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      prog_clock_q <= 1'b0;
      prog_wr_en_q <= 1'b0;
      prog_code_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      prog_clock_q <= (state_d == StPulse);
      if (state_d == StLatch) begin
        prog_wr_en_q <= sw_s[8];
        prog_code_q  <= sw_s[7:0];
      end
    end
  end

  assign prog.prog_clock = prog_clock_q;
  assign prog.prog_wr_en = prog_wr_en_q;
  assign prog.prog_code  = prog_code_q;
  assign prog.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_prog_key_conditioner.sv
// Directed bench for prog_key_conditioner with DEBOUNCE_CYCLES=4, PULSE_CYCLES=3.
module tb_prog_key_conditioner;

  logic       clock = 1'b0;
  logic       reset_N;
  logic       key_N;
  logic       sw_wr_en;
  logic [7:0] sw_code;

  prog_key_conditioner_if prog_bus ();

  prog_key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .PULSE_CYCLES    (3),
    .CNT_W           (8)
  ) dut (
    .clock    (clock),
    .reset_N  (reset_N),
    .key_N    (key_N),
    .sw_wr_en (sw_wr_en),
    .sw_code  (sw_code),
    .prog     (prog_bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor state, updated once per cycle by run_cycles
  int         cyc;
  int         pulses;
  int         first_rise;
  int         high_cycles;
  logic       pc_prev;
  logic [7:0] code_prev;
  logic       wr_prev;
  logic [7:0] pre_code;
  logic       pre_wr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc         = 0;
    pulses      = 0;
    first_rise  = -1;
    high_cycles = 0;
    pc_prev     = prog_bus.prog_clock;
    code_prev   = prog_bus.prog_code;
    wr_prev     = prog_bus.prog_wr_en;
    pre_code    = 8'hxx;
    pre_wr      = 1'bx;
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (prog_bus.prog_clock && !pc_prev) begin
        pulses++;
        if (first_rise < 0) begin
          first_rise = cyc;
          pre_code   = code_prev;
          pre_wr     = wr_prev;
        end
      end
      if (prog_bus.prog_clock) high_cycles++;
      pc_prev   = prog_bus.prog_clock;
      code_prev = prog_bus.prog_code;
      wr_prev   = prog_bus.prog_wr_en;
    end
  endtask

  initial begin
    reset_N  = 1'b0;
    key_N    = 1'b0;
    sw_wr_en = 1'b0;
    sw_code  = 8'h00;

    // 1. Reset state with key already pressed, then a held press
    #12;
    check_eq("rst_prog_clock", {31'd0, prog_bus.prog_clock}, 32'd0);
    check_eq("rst_prog_code", {24'd0, prog_bus.prog_code}, 32'h00);
    check_eq("rst_prog_wr_en", {31'd0, prog_bus.prog_wr_en}, 32'd0);
    check_eq("rst_busy", {31'd0, prog_bus.busy}, 32'd0);
    @(posedge clock);
    #1;
    reset_N = 1'b1;
    clear_mon();
    run_cycles(20);
    // Edge 0 samples key low at tick 1; rise lands on edge 7 = tick 8
    check_eq("t1_pulses", pulses, 1);
    check_eq("t1_rise_tick", first_rise, 8);
    check_eq("t1_width", high_cycles, 3);
    check_eq("t1_busy_held", {31'd0, prog_bus.busy}, 32'd1);
    key_N = 1'b1;
    run_cycles(12);
    check_eq("t1_busy_release", {31'd0, prog_bus.busy}, 32'd0);
    check_eq("t1_pulses_total", pulses, 1);

    // 2. Capture at press, switch change during pulse ignored
    sw_code  = 8'hA5;
    sw_wr_en = 1'b1;
    run_cycles(3);
    clear_mon();
    key_N = 1'b0;
    run_cycles(9);
    check_eq("t2_in_pulse", {31'd0, prog_bus.prog_clock}, 32'd1);
    sw_code  = 8'h3C;
    sw_wr_en = 1'b0;
    run_cycles(11);
    check_eq("t2_pre_code", {24'd0, pre_code}, 32'hA5);
    check_eq("t2_pre_wr", {31'd0, pre_wr}, 32'd1);
    check_eq("t2_code_hold", {24'd0, prog_bus.prog_code}, 32'hA5);
    check_eq("t2_wr_hold", {31'd0, prog_bus.prog_wr_en}, 32'd1);
    check_eq("t2_pulses", pulses, 1);
    key_N = 1'b1;
    run_cycles(12);
    check_eq("t2_code_after", {24'd0, prog_bus.prog_code}, 32'hA5);
    check_eq("t2_busy_idle", {31'd0, prog_bus.busy}, 32'd0);

    // 3. Bouncy press rejected
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      key_N = (k % 2 == 0) ? 1'b0 : 1'b1;
      run_cycles(2);
    end
    key_N = 1'b1;
    run_cycles(14);
    check_eq("t3_pulses", pulses, 0);
    check_eq("t3_busy", {31'd0, prog_bus.busy}, 32'd0);

    // 4. Bouncy release gives no second pulse; next clean press gives one
    clear_mon();
    key_N = 1'b0;
    run_cycles(20);
    check_eq("t4_first_pulse", pulses, 1);
    clear_mon();
    for (int k = 0; k < 6; k++) begin
      key_N = (k % 2 == 0) ? 1'b1 : 1'b0;
      run_cycles(1);
    end
    key_N = 1'b1;
    run_cycles(20);
    check_eq("t4_release_pulses", pulses, 0);
    check_eq("t4_busy_idle", {31'd0, prog_bus.busy}, 32'd0);
    run_cycles(10);
    clear_mon();
    key_N = 1'b0;
    run_cycles(20);
    check_eq("t4_second_press", pulses, 1);
    key_N = 1'b1;
    run_cycles(12);

    // 5. Reset in the second cycle of PULSE
    sw_code  = 8'h81;
    sw_wr_en = 1'b1;
    run_cycles(3);
    clear_mon();
    key_N = 1'b0;
    run_cycles(9);
    check_eq("t5_pulse_cycle2", {31'd0, prog_bus.prog_clock}, 32'd1);
    check_eq("t5_code_before", {24'd0, prog_bus.prog_code}, 32'h81);
    #2;
    reset_N = 1'b0;
    #1;
    check_eq("t5_rst_prog_clock", {31'd0, prog_bus.prog_clock}, 32'd0);
    check_eq("t5_rst_busy", {31'd0, prog_bus.busy}, 32'd0);
    check_eq("t5_rst_code", {24'd0, prog_bus.prog_code}, 32'h00);
    check_eq("t5_rst_wr", {31'd0, prog_bus.prog_wr_en}, 32'd0);
    key_N = 1'b1;
    @(posedge clock);
    #1;
    reset_N = 1'b1;
    run_cycles(6);
    check_eq("t5_busy_after", {31'd0, prog_bus.busy}, 32'd0);

    // 6. Long hold: single pulse, or auto-repeat at +100 then every 40
    clear_mon();
    key_N = 1'b0;
    run_cycles(300);
`ifdef AUTO_REPEAT_EN
    check_eq("t6_pulses", pulses, 6);
`else
    check_eq("t6_pulses", pulses, 1);
`endif
    check_eq("t6_rise_tick", first_rise, 8);
    key_N = 1'b1;
    run_cycles(12);
    check_eq("t6_busy_idle", {31'd0, prog_bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
